// File: rtl/ts_audio_mixer.sv
// TurboSound stereo mixer: snapshots two YM2203 source sets per CE_SAMPLE, accumulates them
// serially and saturates to signed 16-bit L/R. Optional DC blocker enabled by TS_DC_FILTER_EN.
module ts_audio_mixer #(
  parameter int PSG_SHIFT = 4,
  parameter int FM_SHIFT  = 4,
  parameter int DC_K      = 10
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CE_SAMPLE,
  input  logic [1:0]         STEREO,
  input  logic               TS_ENA,
  input  logic               MUTE,
  input  logic [7:0]         PSG0_A,
  input  logic [7:0]         PSG0_B,
  input  logic [7:0]         PSG0_C,
  input  logic [10:0]        FM0,
  input  logic [7:0]         PSG1_A,
  input  logic [7:0]         PSG1_B,
  input  logic [7:0]         PSG1_C,
  input  logic [10:0]        FM1,
  output logic signed [15:0] AUDIO_L,
  output logic signed [15:0] AUDIO_R,
  output logic               VALID,
  output logic               BUSY,
  output logic               OVERRUN,
  output logic [2:0]         STATE_DBG
);

  // Handshake: CE_SAMPLE is a one-clock strobe with no backpressure; it is accepted only in
  // IDLE. VALID pulses for exactly one clock, during which AUDIO_L/R already hold the new sample.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SNAP = 3'd1;
  localparam logic [2:0] ST_ACC  = 3'd2;
  localparam logic [2:0] ST_SAT  = 3'd3;
`ifdef TS_DC_FILTER_EN
  localparam logic [2:0] ST_DCF  = 3'd4;
`endif
  localparam logic [2:0] ST_OUT  = 3'd5;

  logic [2:0]         state;
  logic [2:0]         step;
  logic [7:0]         psg_snap [6];
  logic [10:0]        fm_snap  [2];
  logic [1:0]         stereo_snap;
  logic               ts_ena_snap;
  logic               mute_snap;
  logic [12:0]        psg_l;
  logic [12:0]        psg_r;
  logic signed [12:0] fm_sum;

  logic               chip;
  logic [1:0]         ch;
  logic               chip_on;
  logic               is_fm;
  logic [7:0]         psg_val;
  logic [1:0]         w_l;
  logic [1:0]         w_r;
  logic [12:0]        term_l;
  logic [12:0]        term_r;
  logic [10:0]        fm_sel;
  logic signed [12:0] fm_term;

  logic signed [19:0] offset;
  logic signed [19:0] psg_c_l;
  logic signed [19:0] psg_c_r;
  logic signed [19:0] fm_ext;
  logic signed [19:0] side_l;
  logic signed [19:0] side_r;

  function automatic logic signed [15:0] sat16(input logic signed [19:0] v);
    if (v > 20'sh07FFF)      return 16'sh7FFF;
    else if (v < 20'shF8000) return 16'sh8000;
    else                     return v[15:0];
  endfunction

  function automatic logic [12:0] weigh(input logic [7:0] v, input logic [1:0] w);
    case (w)
      2'd2:    return {4'd0, v, 1'b0};
      2'd1:    return {5'd0, v};
      default: return 13'd0;
    endcase
  endfunction

  // Step 0..7 walks A0,B0,C0,FM0,A1,B1,C1,FM1; the step index selects source and pan weights.
  always_comb begin
    chip    = step[2];
    ch      = step[1:0];
    chip_on = !chip || ts_ena_snap;
    is_fm   = (ch == 2'd3);
    case ({chip, ch})
      3'd0:    psg_val = psg_snap[0];
      3'd1:    psg_val = psg_snap[1];
      3'd2:    psg_val = psg_snap[2];
      3'd4:    psg_val = psg_snap[3];
      3'd5:    psg_val = psg_snap[4];
      3'd6:    psg_val = psg_snap[5];
      default: psg_val = 8'd0;
    endcase
    w_l = 2'd1;
    w_r = 2'd1;
    case (stereo_snap)
      2'd1: begin
        case (ch)
          2'd0:    begin w_l = 2'd2; w_r = 2'd0; end
          2'd2:    begin w_l = 2'd0; w_r = 2'd2; end
          default: begin w_l = 2'd1; w_r = 2'd1; end
        endcase
      end
      2'd2: begin
        case (ch)
          2'd0:    begin w_l = 2'd2; w_r = 2'd0; end
          2'd1:    begin w_l = 2'd0; w_r = 2'd2; end
          default: begin w_l = 2'd1; w_r = 2'd1; end
        endcase
      end
      default: begin w_l = 2'd1; w_r = 2'd1; end
    endcase
    term_l  = weigh(psg_val, w_l);
    term_r  = weigh(psg_val, w_r);
    fm_sel  = chip ? fm_snap[1] : fm_snap[0];
    fm_term = {{2{fm_sel[10]}}, fm_sel};
  end

  // Each mixed chip contributes a PSG midpoint of 382 that is removed before scaling.
  always_comb begin
    offset  = ts_ena_snap ? 20'sd764 : 20'sd382;
    psg_c_l = $signed({7'd0, psg_l}) - offset;
    psg_c_r = $signed({7'd0, psg_r}) - offset;
    fm_ext  = {{7{fm_sum[12]}}, fm_sum};
    side_l  = (psg_c_l <<< PSG_SHIFT) + (fm_ext <<< FM_SHIFT);
    side_r  = (psg_c_r <<< PSG_SHIFT) + (fm_ext <<< FM_SHIFT);
  end

`ifdef TS_DC_FILTER_EN
  logic signed [15:0] sat_l;
  logic signed [15:0] sat_r;
  logic signed [19:0] xp_l;
  logic signed [19:0] yp_l;
  logic signed [19:0] xp_r;
  logic signed [19:0] yp_r;
  logic signed [19:0] x_l;
  logic signed [19:0] x_r;
  logic signed [19:0] y_l;
  logic signed [19:0] y_r;

  always_comb begin
    x_l = {{4{sat_l[15]}}, sat_l};
    x_r = {{4{sat_r[15]}}, sat_r};
    y_l = x_l - xp_l + yp_l - (yp_l >>> DC_K);
    y_r = x_r - xp_r + yp_r - (yp_r >>> DC_K);
  end
`else
  logic unused_dc_k;
  assign unused_dc_k = (DC_K != 0);
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      step        <= 3'd0;
      for (int i = 0; i < 6; i++) psg_snap[i] <= 8'd0;
      fm_snap[0]  <= 11'd0;
      fm_snap[1]  <= 11'd0;
      stereo_snap <= 2'd0;
      ts_ena_snap <= 1'b0;
      mute_snap   <= 1'b0;
      psg_l       <= 13'd0;
      psg_r       <= 13'd0;
      fm_sum      <= 13'sd0;
      AUDIO_L     <= 16'sd0;
      AUDIO_R     <= 16'sd0;
      VALID       <= 1'b0;
      OVERRUN     <= 1'b0;
`ifdef TS_DC_FILTER_EN
      sat_l       <= 16'sd0;
      sat_r       <= 16'sd0;
      xp_l        <= 20'sd0;
      yp_l        <= 20'sd0;
      xp_r        <= 20'sd0;
      yp_r        <= 20'sd0;
`endif
    end else begin
      VALID <= 1'b0;
      if (CE_SAMPLE && (state != ST_IDLE)) OVERRUN <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (CE_SAMPLE) state <= ST_SNAP;
        end
        ST_SNAP: begin
          psg_snap[0] <= PSG0_A;
          psg_snap[1] <= PSG0_B;
          psg_snap[2] <= PSG0_C;
          psg_snap[3] <= PSG1_A;
          psg_snap[4] <= PSG1_B;
          psg_snap[5] <= PSG1_C;
          fm_snap[0]  <= FM0;
          fm_snap[1]  <= FM1;
          stereo_snap <= STEREO;
          ts_ena_snap <= TS_ENA;
          mute_snap   <= MUTE;
          psg_l       <= 13'd0;
          psg_r       <= 13'd0;
          fm_sum      <= 13'sd0;
          step        <= 3'd0;
          state       <= ST_ACC;
        end
        ST_ACC: begin
          if (chip_on) begin
            if (is_fm) begin
              fm_sum <= fm_sum + fm_term;
            end else begin
              psg_l <= psg_l + term_l;
              psg_r <= psg_r + term_r;
            end
          end
          step <= step + 3'd1;
          if (step == 3'd7) state <= ST_SAT;
        end
`ifdef TS_DC_FILTER_EN
        ST_SAT: begin
          sat_l <= sat16(side_l);
          sat_r <= sat16(side_r);
          state <= ST_DCF;
        end
        ST_DCF: begin
          AUDIO_L <= mute_snap ? 16'sd0 : sat16(y_l);
          AUDIO_R <= mute_snap ? 16'sd0 : sat16(y_r);
          // A muted sample leaves the filter history untouched.
          if (!mute_snap) begin
            xp_l <= x_l;
            yp_l <= y_l;
            xp_r <= x_r;
            yp_r <= y_r;
          end
          VALID <= 1'b1;
          state <= ST_OUT;
        end
`else
        ST_SAT: begin
          AUDIO_L <= mute_snap ? 16'sd0 : sat16(side_l);
          AUDIO_R <= mute_snap ? 16'sd0 : sat16(side_r);
          VALID   <= 1'b1;
          state   <= ST_OUT;
        end
`endif
        ST_OUT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY      = (state != ST_IDLE);
  assign STATE_DBG = state;

endmodule

// File: tb/tb_ts_audio_mixer.sv
// Bench for ts_audio_mixer: directed and random samples checked against an arithmetic mix model.
module tb_ts_audio_mixer;

`ifdef TS_DC_FILTER_EN
  localparam int EXP_LAT = 12;
`else
  localparam int EXP_LAT = 11;
`endif

  logic               CLK = 1'b0;
  logic               RESET;
  logic               CE_SAMPLE;
  logic [1:0]         STEREO;
  logic               TS_ENA;
  logic               MUTE;
  logic [7:0]         PSG0_A, PSG0_B, PSG0_C, PSG1_A, PSG1_B, PSG1_C;
  logic [10:0]        FM0, FM1;
  logic signed [15:0] AUDIO_L, AUDIO_R;
  logic               VALID, BUSY, OVERRUN;
  logic [2:0]         STATE_DBG;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  int          dc_xp[2];
  int          dc_yp[2];

  ts_audio_mixer dut (
    .CLK(CLK), .RESET(RESET), .CE_SAMPLE(CE_SAMPLE), .STEREO(STEREO), .TS_ENA(TS_ENA),
    .MUTE(MUTE), .PSG0_A(PSG0_A), .PSG0_B(PSG0_B), .PSG0_C(PSG0_C), .FM0(FM0),
    .PSG1_A(PSG1_A), .PSG1_B(PSG1_B), .PSG1_C(PSG1_C), .FM1(FM1),
    .AUDIO_L(AUDIO_L), .AUDIO_R(AUDIO_R), .VALID(VALID), .BUSY(BUSY), .OVERRUN(OVERRUN),
    .STATE_DBG(STATE_DBG)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    CE_SAMPLE = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    dc_xp = '{0, 0};
    dc_yp = '{0, 0};
    exp_q.delete();
  endtask

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: per-side weighted PSG sum, centred, scaled by 16, plus FM scaled by 16.
  function automatic void model(input int psg[6], input int fm[2], input int st, input int ts,
                                input int mu, output int l, output int r);
    int pl, pr, nchips, fms, a, b, c, x[2], y;
    pl = 0;
    pr = 0;
    nchips = ts ? 2 : 1;
    for (int k = 0; k < nchips; k++) begin
      a = psg[3*k]; b = psg[3*k+1]; c = psg[3*k+2];
      case (st)
        1: begin pl += 2*a + b; pr += b + 2*c; end
        2: begin pl += 2*a + c; pr += c + 2*b; end
        default: begin pl += a + b + c; pr += a + b + c; end
      endcase
    end
    fms = fm[0] + (ts ? fm[1] : 0);
    x[0] = clamp16((pl - 382*nchips)*16 + fms*16);
    x[1] = clamp16((pr - 382*nchips)*16 + fms*16);
`ifdef TS_DC_FILTER_EN
    for (int k = 0; k < 2; k++) begin
      y = x[k] - dc_xp[k] + dc_yp[k] - (dc_yp[k] >>> 10);
      y = (y <<< 12) >>> 12;
      if (!mu) begin
        dc_xp[k] = x[k];
        dc_yp[k] = y;
      end
      x[k] = clamp16(y);
    end
`endif
    l = mu ? 0 : x[0];
    r = mu ? 0 : x[1];
  endfunction

  // driver tasks
  task automatic drive_inputs(input int psg[6], input int fm[2], input int st, input int ts,
                              input int mu);
    PSG0_A = 8'(psg[0]); PSG0_B = 8'(psg[1]); PSG0_C = 8'(psg[2]);
    PSG1_A = 8'(psg[3]); PSG1_B = 8'(psg[4]); PSG1_C = 8'(psg[5]);
    FM0 = 11'(fm[0]); FM1 = 11'(fm[1]);
    STEREO = 2'(st); TS_ENA = 1'(ts); MUTE = 1'(mu);
  endtask

  task automatic scramble_inputs();
    PSG0_A = 8'($urandom); PSG0_B = 8'($urandom); PSG0_C = 8'($urandom);
    PSG1_A = 8'($urandom); PSG1_B = 8'($urandom); PSG1_C = 8'($urandom);
    FM0 = 11'($urandom); FM1 = 11'($urandom);
    STEREO = 2'($urandom); TS_ENA = 1'($urandom); MUTE = 1'($urandom);
  endtask

  task automatic do_sample(input int psg[6], input int fm[2], input int st, input int ts,
                           input int mu, output int got_l, output int got_r);
    int el, er, lat;
    logic [31:0] e;
    model(psg, fm, st, ts, mu, el, er);
    exp_q.push_back({el[15:0], er[15:0]});
    @(negedge CLK);
    drive_inputs(psg, fm, st, ts, mu);
    CE_SAMPLE = 1'b1;
    @(negedge CLK);
    CE_SAMPLE = 1'b0;
    check_val("busy_snap", int'(BUSY), 1);
    @(negedge CLK);
    scramble_inputs();
    lat = 2;
    while (VALID !== 1'b1 && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    check_val("latency", lat, EXP_LAT);
    e = exp_q.pop_front();
    check_val("audio_l", int'(AUDIO_L), int'($signed(e[31:16])));
    check_val("audio_r", int'(AUDIO_R), int'($signed(e[15:0])));
    check_val("busy_out", int'(BUSY), 1);
    got_l = int'(AUDIO_L);
    got_r = int'(AUDIO_R);
    repeat (2) @(negedge CLK);
    check_val("valid_pulse", int'(VALID), 0);
    check_val("busy_idle", int'(BUSY), 0);
    check_val("hold_l", int'(AUDIO_L), int'($signed(e[31:16])));
  endtask

  initial begin
    int psg[6];
    int fm[2];
    int gl, gr, cnt, lat_first, prev_l;
    logic [31:0] e;

    RESET = 1'b0;
    CE_SAMPLE = 1'b0;
    psg = '{0, 0, 0, 0, 0, 0};
    fm = '{0, 0};
    drive_inputs(psg, fm, 0, 0, 0);
    do_reset();
    check_val("rst_l", int'(AUDIO_L), 0);
    check_val("rst_r", int'(AUDIO_R), 0);
    check_val("rst_valid", int'(VALID), 0);
    check_val("rst_busy", int'(BUSY), 0);
    check_val("rst_overrun", int'(OVERRUN), 0);

    // silence, ABC, single chip
    do_sample(psg, fm, 1, 0, 0, gl, gr);
`ifndef TS_DC_FILTER_EN
    check_val("t1_l", gl, -6112);
    check_val("t1_r", gr, -6112);
`endif
    psg = '{255, 0, 0, 0, 0, 0};
    do_sample(psg, fm, 1, 0, 0, gl, gr);
`ifndef TS_DC_FILTER_EN
    check_val("t2_abc_l", gl, 2048);
    check_val("t2_abc_r", gr, -6112);
`endif
    psg = '{0, 255, 0, 0, 0, 0};
    do_sample(psg, fm, 2, 0, 0, gl, gr);
`ifndef TS_DC_FILTER_EN
    check_val("t2_acb_l", gl, -6112);
    check_val("t2_acb_r", gr, 2048);
`endif
    psg = '{255, 255, 255, 255, 255, 255};
    fm = '{1023, 1023};
    do_sample(psg, fm, 0, 1, 0, gl, gr);
`ifndef TS_DC_FILTER_EN
    check_val("t3_pos_l", gl, 32767);
    check_val("t3_pos_r", gr, 32767);
`endif
    psg = '{0, 0, 0, 0, 0, 0};
    fm = '{-1024, -1024};
    do_sample(psg, fm, 0, 1, 0, gl, gr);
`ifndef TS_DC_FILTER_EN
    check_val("t3_neg_l", gl, -32768);
    check_val("t3_neg_r", gr, -32768);
`endif
    // muted sample after a non-zero one
    psg = '{200, 17, 90, 33, 250, 5};
    fm = '{300, -500};
    do_sample(psg, fm, 3, 1, 1, gl, gr);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 6; k++) psg[k] = int'($urandom_range(0, 255));
      fm[0] = int'($urandom_range(0, 2047)) - 1024;
      fm[1] = int'($urandom_range(0, 2047)) - 1024;
      do_sample(psg, fm, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? 1 : 0, gl, gr);
    end

    // second strobe while busy is dropped and flagged
    psg = '{10, 20, 30, 0, 0, 0};
    fm = '{-77, 0};
    model(psg, fm, 1, 0, 0, gl, gr);
    exp_q.push_back({gl[15:0], gr[15:0]});
    @(negedge CLK);
    drive_inputs(psg, fm, 1, 0, 0);
    CE_SAMPLE = 1'b1;
    @(negedge CLK);
    CE_SAMPLE = 1'b0;
    repeat (4) @(negedge CLK);
    check_val("ovr_before", int'(OVERRUN), 0);
    CE_SAMPLE = 1'b1;
    @(negedge CLK);
    CE_SAMPLE = 1'b0;
    check_val("ovr_set", int'(OVERRUN), 1);
    cnt = 0;
    lat_first = 0;
    for (int k = 7; k <= 30; k++) begin
      @(negedge CLK);
      if (VALID === 1'b1) begin
        cnt++;
        if (cnt == 1) begin
          lat_first = k;
          e = exp_q.pop_front();
          check_val("ovr_l", int'(AUDIO_L), int'($signed(e[31:16])));
          check_val("ovr_r", int'(AUDIO_R), int'($signed(e[15:0])));
        end
      end
    end
    check_val("ovr_valid_count", cnt, 1);
    check_val("ovr_latency", lat_first, EXP_LAT);
    check_val("ovr_sticky", int'(OVERRUN), 1);
    do_reset();
    check_val("ovr_cleared", int'(OVERRUN), 0);

    // reset in the middle of a muted sample
    psg = '{100, 100, 100, 0, 0, 0};
    fm = '{50, 0};
    do_sample(psg, fm, 1, 0, 0, gl, gr);
    @(negedge CLK);
    drive_inputs(psg, fm, 1, 0, 1);
    CE_SAMPLE = 1'b1;
    @(negedge CLK);
    CE_SAMPLE = 1'b0;
    repeat (4) @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    dc_xp = '{0, 0};
    dc_yp = '{0, 0};
    check_val("abort_busy", int'(BUSY), 0);
    check_val("abort_l", int'(AUDIO_L), 0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (VALID === 1'b1) cnt++;
    end
    check_val("abort_no_valid", cnt, 0);

`ifdef TS_DC_FILTER_EN
    // constant input through the DC blocker decays toward zero
    do_reset();
    psg = '{255, 0, 0, 0, 0, 0};
    fm = '{0, 0};
    do_sample(psg, fm, 1, 0, 0, gl, gr);
    check_val("dc_first", gl, 2048);
    prev_l = gl;
    for (int n = 1; n < 4096; n++) begin
      do_sample(psg, fm, 1, 0, 0, gl, gr);
      check_val("dc_mono", (gl <= prev_l && gl >= 0) ? 1 : 0, 1);
      prev_l = gl;
    end
    check_val("dc_decayed", (prev_l < 2048) ? 1 : 0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
